// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants, polarity values and timing helpers
package vga_timing_pkg;
    localparam bit POL_LOW  = 1'b0;
    localparam bit POL_HIGH = 1'b1;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam bit VGA_HS_POL   = POL_LOW;
    localparam bit VGA_VS_POL   = POL_LOW;
    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } sync_t;
    function automatic int timing_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction
    function automatic int coord_w(input int n);
        return n < 2 ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: timing/coordinate bundle from the timing engine to the pixel lookup path
interface vga_timing_if #(
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int ADDR_W  = 19,
    parameter int FRAME_W = 8
);
    logic               hs;
    logic               vs;
    logic               blank_n;
    logic               active;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [ADDR_W-1:0]  addr;
    logic               frame_start;
    logic               line_start;
    logic [FRAME_W-1:0] frame_cnt;
    modport master (output hs, vs, blank_n, active, x, y, addr, frame_start, line_start, frame_cnt);
    modport slave  (input  hs, vs, blank_n, active, x, y, addr, frame_start, line_start, frame_cnt);
endinterface

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: N-stage shift register with per-bit reset value, pass-through when N=0
module vga_sync_delay #(
    parameter int             W       = 3,
    parameter int             N       = 2,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    if (N == 0) begin : g_thru
        assign q = d;
    end else begin : g_pipe
        logic [N-1:0][W-1:0] sr;
        logic [N:0][W-1:0]   chain;
        assign chain = {sr, d};
        always_ff @(posedge clk)
            sr <= rst ? {N{RST_VAL}} : chain[N-1:0];
        assign q = sr[N-1];
    end
endmodule

// File: rtl/vga_timing_engine.sv
// vga_timing_engine: parametrised VGA H/V timing, coordinates, scaled framebuffer address and delayed syncs
module vga_timing_engine
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter bit HS_POL     = VGA_HS_POL,
    parameter bit VS_POL     = VGA_VS_POL,
    parameter int SCALE_SH   = 0,
    parameter int PIPE_DEPTH = 2,
    parameter int ADDR_W     = 19,
    parameter int FRAME_W    = 8
) (
    input  logic          iVGA_CLK,
    input  logic          reset,
    vga_timing_if.master  vga
);
    localparam int H_TOTAL   = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL   = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int X_W       = coord_w(H_ACTIVE);
    localparam int Y_W       = coord_w(V_ACTIVE);
    localparam int HC_W      = coord_w(H_TOTAL);
    localparam int VC_W      = coord_w(V_TOTAL);
    localparam int REP_MAX   = (1 << SCALE_SH) - 1;
    localparam int LINE_STEP = H_ACTIVE >> SCALE_SH;
    localparam sync_t SYNC_IDLE = '{hs: !HS_POL, vs: !VS_POL, blank_n: 1'b0};
    if (SCALE_SH < 0 || SCALE_SH > 3) begin : g_bad_scale
        $fatal(1, "SCALE_SH out of range 0..3");
    end
    if (PIPE_DEPTH < 0 || PIPE_DEPTH > 8) begin : g_bad_pipe
        $fatal(1, "PIPE_DEPTH out of range 0..8");
    end
    if ((H_ACTIVE % (1 << SCALE_SH)) != 0 || (V_ACTIVE % (1 << SCALE_SH)) != 0) begin : g_bad_active
        $fatal(1, "active size not a multiple of the replication factor");
    end
    if (((64'(H_ACTIVE) * 64'(V_ACTIVE)) >> (2 * SCALE_SH)) > (64'(1) << ADDR_W)) begin : g_bad_addr
        $fatal(1, "ADDR_W too narrow for the scaled framebuffer");
    end
    if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
        $fatal(1, "porch and sync widths must be at least 1");
    end
    logic [HC_W-1:0]    h;
    logic [VC_W-1:0]    v;
    logic [X_W-1:0]     col;
    logic [2:0]         hrep;
    logic [2:0]         vrep;
    logic [ADDR_W-1:0]  line_base;
    logic [FRAME_W-1:0] frame_cnt;
    logic               h_end;
    logic               v_end;
    logic               active;
    logic               hs_on;
    logic               vs_on;
    sync_t              dec;
    sync_t              dly;
    always_comb begin
        h_end  = h == HC_W'(H_TOTAL - 1);
        v_end  = v == VC_W'(V_TOTAL - 1);
        active = h < HC_W'(H_ACTIVE) && v < VC_W'(V_ACTIVE);
        hs_on  = h >= HC_W'(H_ACTIVE + H_FP) && h < HC_W'(H_ACTIVE + H_FP + H_SYNC);
        vs_on  = v >= VC_W'(V_ACTIVE + V_FP) && v < VC_W'(V_ACTIVE + V_FP + V_SYNC);
        dec    = '{hs: hs_on ? HS_POL : !HS_POL, vs: vs_on ? VS_POL : !VS_POL, blank_n: active};
    end
    // col/hrep and line_base/vrep replace the multiply by the scaled line width
    always_ff @(posedge iVGA_CLK) begin
        if (reset) begin
            h         <= HC_W'(H_TOTAL - 1);
            v         <= VC_W'(V_TOTAL - 1);
            col       <= '0;
            hrep      <= '0;
            vrep      <= '0;
            line_base <= '0;
            frame_cnt <= '0;
        end else begin
            h    <= h_end ? '0 : h + 1'b1;
            col  <= h_end ? '0 : (hrep == 3'(REP_MAX) ? col + 1'b1 : col);
            hrep <= (h_end || hrep == 3'(REP_MAX)) ? '0 : hrep + 1'b1;
            if (h_end) begin
                v         <= v_end ? '0 : v + 1'b1;
                vrep      <= (v_end || vrep == 3'(REP_MAX)) ? '0 : vrep + 1'b1;
                line_base <= v_end ? '0
                           : (v < VC_W'(V_ACTIVE) && vrep == 3'(REP_MAX)) ? line_base + ADDR_W'(LINE_STEP)
                           : line_base;
            end
            if (h_end && v_end)
                frame_cnt <= frame_cnt + 1'b1;
        end
    end
    vga_sync_delay #(
        .W       ($bits(sync_t)),
        .N       (PIPE_DEPTH),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_delay (
        .clk (iVGA_CLK),
        .rst (reset),
        .d   (dec),
        .q   (dly)
    );
    assign vga.hs          = dly.hs;
    assign vga.vs          = dly.vs;
    assign vga.blank_n     = dly.blank_n;
    assign vga.active      = active;
    assign vga.x           = active ? X_W'(h) : '0;
    assign vga.y           = active ? Y_W'(v) : '0;
    assign vga.addr        = active ? line_base + ADDR_W'(col) : '0;
    assign vga.frame_start = h == '0 && v == '0;
    assign vga.line_start  = h == '0 && v < VC_W'(V_ACTIVE);
    assign vga.frame_cnt   = frame_cnt;
endmodule

// File: tb/tb_vga_timing_engine.sv
// tb_vga_timing_engine: directed checks of an unscaled/no-delay instance and a scaled/delayed/2-bit-frame instance
module tb_vga_timing_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    vga_timing_if #(.X_W(3), .Y_W(2), .ADDR_W(6), .FRAME_W(8)) va ();
    vga_timing_if #(.X_W(3), .Y_W(2), .ADDR_W(6), .FRAME_W(2)) vb ();
    vga_timing_engine #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .SCALE_SH(0), .PIPE_DEPTH(0),
        .ADDR_W(6), .FRAME_W(8)
    ) dut_a (.iVGA_CLK(clk), .reset(rst), .vga(va));
    vga_timing_engine #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .SCALE_SH(1), .PIPE_DEPTH(2),
        .ADDR_W(6), .FRAME_W(2)
    ) dut_b (.iVGA_CLK(clk), .reset(rst), .vga(vb));
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask
    // {hs, vs, blank_n} for step k after release (14-pixel lines, 7-line frames); k<0 is idle
    function automatic logic [2:0] dec(input int k);
        int h;
        int v;
        if (k < 0) return 3'b110;
        h = k % 14;
        v = (k / 14) % 7;
        return {!(h >= 10 && h < 12), !(v == 5), (h < 8 && v < 4)};
    endfunction
    initial begin
        int h;
        int v;
        int fr;
        logic [2:0] e;
        logic [2:0] ed;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst A.hs", va.hs, 1);
        chk("rst A.vs", va.vs, 1);
        chk("rst A.blank_n", va.blank_n, 0);
        chk("rst A.active", va.active, 0);
        chk("rst A.addr", va.addr, 0);
        chk("rst A.frame_start", va.frame_start, 0);
        chk("rst A.line_start", va.line_start, 0);
        chk("rst A.frame_cnt", va.frame_cnt, 0);
        chk("rst B.hs", vb.hs, 1);
        chk("rst B.blank_n", vb.blank_n, 0);
        chk("rst B.frame_cnt", vb.frame_cnt, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("first A.frame_start", va.frame_start, 1);
        chk("first A.line_start", va.line_start, 1);
        chk("first A.x", va.x, 0);
        chk("first A.y", va.y, 0);
        chk("first A.addr", va.addr, 0);
        chk("first A.frame_cnt", va.frame_cnt, 1);
        chk("first B.blank_n", vb.blank_n, 0);
        for (int k = 0; k < 5 * 98 + 33; k++) begin
            h  = k % 14;
            v  = (k / 14) % 7;
            fr = k / 98 + 1;
            e  = dec(k);
            ed = dec(k - 2);
            chk($sformatf("A.hs k=%0d", k), va.hs, e[2]);
            chk($sformatf("A.vs k=%0d", k), va.vs, e[1]);
            chk($sformatf("A.blank_n k=%0d", k), va.blank_n, e[0]);
            chk($sformatf("A.active k=%0d", k), va.active, e[0]);
            chk($sformatf("A.x k=%0d", k), va.x, e[0] ? h : 0);
            chk($sformatf("A.y k=%0d", k), va.y, e[0] ? v : 0);
            chk($sformatf("A.addr k=%0d", k), va.addr, e[0] ? v * 8 + h : 0);
            chk($sformatf("A.frame_start k=%0d", k), va.frame_start, h == 0 && v == 0);
            chk($sformatf("A.line_start k=%0d", k), va.line_start, h == 0 && v < 4);
            chk($sformatf("A.frame_cnt k=%0d", k), va.frame_cnt, fr % 256);
            chk($sformatf("B.hs k=%0d", k), vb.hs, ed[2]);
            chk($sformatf("B.vs k=%0d", k), vb.vs, ed[1]);
            chk($sformatf("B.blank_n k=%0d", k), vb.blank_n, ed[0]);
            chk($sformatf("B.active k=%0d", k), vb.active, e[0]);
            chk($sformatf("B.addr k=%0d", k), vb.addr, e[0] ? (v / 2) * 4 + h / 2 : 0);
            chk($sformatf("B.frame_cnt k=%0d", k), vb.frame_cnt, fr % 4);
            @(negedge clk);
        end
        chk("mid A.x", va.x, 5);
        chk("mid A.y", va.y, 2);
        chk("mid B.addr", vb.addr, 6);
        chk("mid B.blank_n", vb.blank_n, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid-rst A.hs", va.hs, 1);
        chk("mid-rst A.vs", va.vs, 1);
        chk("mid-rst A.blank_n", va.blank_n, 0);
        chk("mid-rst A.active", va.active, 0);
        chk("mid-rst A.x", va.x, 0);
        chk("mid-rst A.y", va.y, 0);
        chk("mid-rst A.addr", va.addr, 0);
        chk("mid-rst A.frame_start", va.frame_start, 0);
        chk("mid-rst A.line_start", va.line_start, 0);
        chk("mid-rst A.frame_cnt", va.frame_cnt, 0);
        chk("mid-rst B.blank_n", vb.blank_n, 0);
        chk("mid-rst B.hs", vb.hs, 1);
        chk("mid-rst B.frame_cnt", vb.frame_cnt, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("restart A.frame_start", va.frame_start, 1);
        chk("restart A.frame_cnt", va.frame_cnt, 1);
        chk("restart A.x", va.x, 0);
        chk("restart A.y", va.y, 0);
        chk("restart B.frame_cnt", vb.frame_cnt, 1);
        chk("restart B.blank_n", vb.blank_n, 0);
        chk("restart B.addr", vb.addr, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_timing_engine.md
Name: vga_timing_engine

Overview:
Parametrised successor to the fixed-640x480 VGA front end. It generates H/V timing from parameters, with configurable sync polarity. It produces pixel coordinates and a framebuffer address with optional power-of-two pixel replication, plus frame/line strobes and a frame counter. HS/VS/BLANK_n are delayed by a parameterised pipeline so they line up with downstream index-ROM and palette latency. It sits between the pixel clock and the index/palette lookup path.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, asserted level of o_hs (0 = active-low)
VS_POL, 0, asserted level of o_vs
SCALE_SH, 0, log2 pixel replication factor, range 0..3
PIPE_DEPTH, 2, sync/blank delay stages, range 0..8
ADDR_W, 19, framebuffer address width
FRAME_W, 8, frame counter width

Ports:
iVGA_CLK  in  1  pixel clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
o_hs  out  1  horizontal sync, delayed PIPE_DEPTH cycles
o_vs  out  1  vertical sync, delayed PIPE_DEPTH cycles
o_blank_n  out  1  high during the active region, delayed PIPE_DEPTH cycles
o_active  out  1  undelayed active-region flag
o_x  out  clog2(H_ACTIVE)  active column; 0 when inactive
o_y  out  clog2(V_ACTIVE)  active row; 0 when inactive
o_addr  out  ADDR_W  scaled framebuffer address; 0 when inactive
o_frame_start  out  1  one-cycle pulse at (h,v)=(0,0)
o_line_start  out  1  one-cycle pulse at h=0 while v<V_ACTIVE
o_frame_cnt  out  FRAME_W  frame counter

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise. Region order within a line and within a frame is active, FP, sync, BP.
- Counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1). h increments every cycle and wraps to 0. v increments when h wraps, and itself wraps V_TOTAL-1 -> 0.
- Reset loads h=H_TOTAL-1 and v=V_TOTAL-1. This is the last blanking pixel, so the first edge after reset deasserts lands on (0,0).
- Undelayed outputs are combinational decodes of h and v:
  - active = (h<H_ACTIVE) && (v<V_ACTIVE).
  - hs asserted when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vs uses the same rule on v with the V parameters.
- o_addr = (o_y>>SCALE_SH)*(H_ACTIVE>>SCALE_SH) + (o_x>>SCALE_SH). It is built with a line-base accumulator plus a column sub-counter; no multiplier is used.
- Address edge cases:
  - Each address is repeated for 2^SCALE_SH consecutive pixels.
  - The line base advances only on every 2^SCALE_SH-th active line.
  - The line base clears at the frame start.
- Delay line: PIPE_DEPTH registers on {hs, vs, blank_n}.
  - Reset loads every stage with inactive values: hs=~HS_POL, vs=~VS_POL, blank_n=0.
  - With PIPE_DEPTH=0, the decodes pass straight through combinationally.
- o_frame_cnt:
  - Resets to 0.
  - Increments on the (H_TOTAL-1,V_TOTAL-1)->(0,0) transition, including the first one after reset, so it reads 1 during the first frame.
  - Wraps modulo 2^FRAME_W.
- Reset values of all outputs: o_hs=~HS_POL, o_vs=~VS_POL, o_blank_n=0, o_active=0, o_x=0, o_y=0, o_addr=0, o_frame_start=0, o_line_start=0, o_frame_cnt=0.
- Reset asserted mid-frame: on the next edge, all counters, the accumulator and the pipeline return to reset state. No partial line is finished.
- Elaboration checks:
  - H_ACTIVE and V_ACTIVE are multiples of 2^SCALE_SH.
  - ADDR_W holds (H_ACTIVE*V_ACTIVE)>>(2*SCALE_SH).
  - All porch and sync parameters are >=1.
  - Any violation is a $fatal.

Decomposition:
- Package vga_timing_pkg holds:
  - the 640x480@60 timing constants;
  - the total-computation functions;
  - the sync-polarity localparams.
- One sub-module, vga_sync_delay: a parametrised N-stage shift register with a reset value per bit, instanced once for {hs, vs, blank_n}.

Test Plan:
1. Sim params H=8/2/2/2, V=4/1/1/1, POL 0, PIPE_DEPTH 0. Hold reset 3 cycles, then release -> during reset o_hs=o_vs=1, o_blank_n=0, o_frame_cnt=0. On the first cycle after release: o_frame_start=1, o_line_start=1, o_x=o_y=0, o_addr=0, o_frame_cnt=1.
2. Same params, run 2 lines -> o_hs low exactly at h=10,11 (2 cycles) with period 14. o_vs low for all 14 cycles of v=5. Frame period 98 cycles.
3. SCALE_SH=1 -> row 0 o_addr sequence is 0,0,1,1,2,2,3,3; row 1 is identical; row 2 starts at 4; o_addr=6 at (x=5,y=3).
4. PIPE_DEPTH=2 -> o_blank_n rises exactly 2 cycles after o_active rises. o_hs and o_vs edges are likewise 2 cycles after their decoded transitions.
5. FRAME_W=2, run 5 frames -> o_frame_cnt goes 1,2,3,0,1.
6. Assert reset for 1 cycle at (h=5,v=2) -> the next cycle shows the reset values with the pipeline cleared. After release, the next cycle is (0,0) with o_frame_start=1 and o_frame_cnt=1.
